// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, opcodes and
// ALU operand-B / operation selects.
package multicycle_pkg;

  // FSM state encodings (5-bit, also exported on the debug port)
  localparam logic [4:0] StReset  = 5'd0;
  localparam logic [4:0] StFetch  = 5'd1;
  localparam logic [4:0] StDecode = 5'd2;
  localparam logic [4:0] StAsn3   = 5'd3;
  localparam logic [4:0] StAlu4   = 5'd4;
  localparam logic [4:0] StShift3 = 5'd5;
  localparam logic [4:0] StOri3   = 5'd6;
  localparam logic [4:0] StOri4   = 5'd7;
  localparam logic [4:0] StOri5   = 5'd8;
  localparam logic [4:0] StLoad3  = 5'd9;
  localparam logic [4:0] StLoad4  = 5'd10;
  localparam logic [4:0] StStore3 = 5'd11;
  localparam logic [4:0] StBpz3   = 5'd12;
  localparam logic [4:0] StBz3    = 5'd13;
  localparam logic [4:0] StBnz3   = 5'd14;
  localparam logic [4:0] StFault  = 5'd15;
  localparam logic [4:0] StHalt   = 5'd16;

  // Opcodes (IR[3:0])
  localparam logic [3:0] OpLoad  = 4'b0000;
  localparam logic [3:0] OpStop  = 4'b0001;
  localparam logic [3:0] OpStore = 4'b0010;
  localparam logic [3:0] OpAdd   = 4'b0100;
  localparam logic [3:0] OpBz    = 4'b0101;
  localparam logic [3:0] OpSub   = 4'b0110;
  localparam logic [3:0] OpNand  = 4'b1000;
  localparam logic [3:0] OpBnz   = 4'b1001;
  localparam logic [3:0] OpBpz   = 4'b1101;
  localparam logic [2:0] OpShiftLo = 3'b011;
  localparam logic [2:0] OpOriLo   = 3'b111;

  // ALU operand-B select
  localparam logic [2:0] Alu2Reg   = 3'b000;
  localparam logic [2:0] Alu2One   = 3'b001;
  localparam logic [2:0] Alu2Br    = 3'b010;
  localparam logic [2:0] Alu2Imm   = 3'b011;
  localparam logic [2:0] Alu2Shamt = 3'b100;

  // ALU operation
  localparam logic [2:0] AluAdd   = 3'b000;
  localparam logic [2:0] AluSub   = 3'b001;
  localparam logic [2:0] AluOr    = 3'b010;
  localparam logic [2:0] AluNand  = 3'b011;
  localparam logic [2:0] AluShift = 3'b100;

  // States that wait on the memory handshake
  function automatic logic is_mem_state(input logic [4:0] s);
    return (s == StFetch) || (s == StLoad3) || (s == StStore3);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state counter for one memory access. Counts cycles spent waiting and
// flags expiry once MEM_TIMEOUT wait cycles have elapsed with no ack.
// MEM_TIMEOUT = 0 disables expiry.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TW          = $clog2(MEM_TIMEOUT + 2)
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic waiting,
  output logic expired
);

  localparam logic [TW-1:0] Limit = TW'(MEM_TIMEOUT);

  logic [TW-1:0] count_q, count_d;

  // Next count: clear wins, otherwise count up to the limit and stop there
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (waiting && (count_q < Limit)) begin
      count_d = count_q + TW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (MEM_TIMEOUT != 0) && waiting && (count_q == Limit);

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for the 8-bit multicycle processor with ack-based memory
// handshake, per-access timeout fault and illegal-opcode flagging.
// Optional STOP instruction enabled by defining MULTICYCLE_STOP_EN.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TW          = $clog2(MEM_TIMEOUT + 2)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       N,
  input  logic       Z,
  input  logic [3:0] instr,
  input  logic       mem_ack,
  output logic       PCwrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRload,
  output logic       R1Sel,
  output logic       MDRload,
  output logic       R1R2Load,
  output logic       ALU1,
  output logic       ALUOutWrite,
  output logic       RFWrite,
  output logic       RegIn,
  output logic       FlagWrite,
  output logic [2:0] ALU2,
  output logic [2:0] ALUop,
  output logic       illegal,
  output logic       fault,
  output logic       halted,
  output logic [4:0] state
);

  logic [4:0] state_q, state_d;
  logic [4:0] dec_next;
  logic       dec_illegal;
  logic       in_mem, expired, fault_q;

  assign in_mem = is_mem_state(state_q);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TW         (TW)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (!in_mem || mem_ack),
    .waiting(in_mem && !mem_ack),
    .expired(expired)
  );

  // Opcode decode in priority order
  always_comb begin
    dec_next    = StFetch;
    dec_illegal = 1'b0;
    if ((instr == OpAdd) || (instr == OpSub) || (instr == OpNand)) dec_next = StAsn3;
    else if (instr[2:0] == OpShiftLo) dec_next = StShift3;
    else if (instr[2:0] == OpOriLo)   dec_next = StOri3;
    else if (instr == OpLoad)         dec_next = StLoad3;
    else if (instr == OpStore)        dec_next = StStore3;
    else if (instr == OpBpz)          dec_next = StBpz3;
    else if (instr == OpBz)           dec_next = StBz3;
    else if (instr == OpBnz)          dec_next = StBnz3;
`ifdef MULTICYCLE_STOP_EN
    else if (instr == OpStop)         dec_next = StHalt;
`endif
    else                              dec_illegal = 1'b1;
  end

  // Next-state logic; an ack in the timeout cycle takes priority over expiry
  always_comb begin
    state_d = state_q;
    case (state_q)
      StReset:  state_d = StFetch;
      StFetch:  if (mem_ack) state_d = StDecode; else if (expired) state_d = StFault;
      StDecode: state_d = dec_next;
      StAsn3, StShift3: state_d = StAlu4;
      StAlu4:   state_d = StFetch;
      StOri3:   state_d = StOri4;
      StOri4:   state_d = StOri5;
      StOri5:   state_d = StFetch;
      StLoad3:  if (mem_ack) state_d = StLoad4; else if (expired) state_d = StFault;
      StLoad4:  state_d = StFetch;
      StStore3: if (mem_ack) state_d = StFetch; else if (expired) state_d = StFault;
      StBpz3, StBz3, StBnz3: state_d = StFetch;
      StFault, StHalt: state_d = state_q;
      default:  state_d = StReset;
    endcase
  end

  // State and sticky fault registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StReset;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (expired) fault_q <= 1'b1;
    end
  end

  // Datapath controls, combinational from state and live inputs
  always_comb begin
    PCwrite = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; IRload = 1'b0;
    R1Sel = 1'b0; MDRload = 1'b0; R1R2Load = 1'b0; ALU1 = 1'b0;
    ALUOutWrite = 1'b0; RFWrite = 1'b0; RegIn = 1'b0; FlagWrite = 1'b0;
    ALU2 = Alu2Reg; ALUop = AluAdd;
    illegal = 1'b0;
    case (state_q)
      StFetch: begin
        MemRead = 1'b1; ALU2 = Alu2One; ALUop = AluAdd;
        PCwrite = mem_ack; IRload = mem_ack;
      end
      StDecode: begin
        R1R2Load = 1'b1;
        illegal  = dec_illegal;
      end
      StAsn3: begin
        ALU1 = 1'b1; ALU2 = Alu2Reg; ALUOutWrite = 1'b1; FlagWrite = 1'b1;
        if (instr == OpSub)       ALUop = AluSub;
        else if (instr == OpNand) ALUop = AluNand;
        else                      ALUop = AluAdd;
      end
      StAlu4: RFWrite = 1'b1;
      StShift3: begin
        ALU1 = 1'b1; ALU2 = Alu2Shamt; ALUop = AluShift; ALUOutWrite = 1'b1; FlagWrite = 1'b1;
      end
      StOri3: begin
        R1Sel = 1'b1; R1R2Load = 1'b1;
      end
      StOri4: begin
        ALU1 = 1'b1; ALU2 = Alu2Imm; ALUop = AluOr; ALUOutWrite = 1'b1; FlagWrite = 1'b1;
      end
      StOri5: begin
        R1Sel = 1'b1; RFWrite = 1'b1;
      end
      StLoad3: begin
        MemRead = 1'b1; MDRload = mem_ack;
      end
      StLoad4: begin
        ALUOutWrite = 1'b1; RFWrite = 1'b1; RegIn = 1'b1;
      end
      StStore3: MemWrite = 1'b1;
      StBpz3: begin ALU2 = Alu2Br; PCwrite = ~N; end
      StBz3:  begin ALU2 = Alu2Br; PCwrite = Z;  end
      StBnz3: begin ALU2 = Alu2Br; PCwrite = ~Z; end
      default: ;
    endcase
  end

  assign fault = fault_q;
  assign state = state_q;
`ifdef MULTICYCLE_STOP_EN
  assign halted = (state_q == StHalt);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl (MEM_TIMEOUT = 4). Each instruction
// is expanded into its expected per-cycle control trace from the opcode class,
// flags and chosen wait counts, then replayed against the DUT.
module tb_multicycle_ctrl;

  logic clock, reset, N, Z, mem_ack;
  logic [3:0] instr;
  logic PCwrite, MemRead, MemWrite, IRload, R1Sel, MDRload, R1R2Load, ALU1;
  logic ALUOutWrite, RFWrite, RegIn, FlagWrite, illegal, fault, halted;
  logic [2:0] ALU2, ALUop;
  logic [4:0] state;

  multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clock(clock), .reset(reset), .N(N), .Z(Z), .instr(instr), .mem_ack(mem_ack),
    .PCwrite(PCwrite), .MemRead(MemRead), .MemWrite(MemWrite), .IRload(IRload),
    .R1Sel(R1Sel), .MDRload(MDRload), .R1R2Load(R1R2Load), .ALU1(ALU1),
    .ALUOutWrite(ALUOutWrite), .RFWrite(RFWrite), .RegIn(RegIn), .FlagWrite(FlagWrite),
    .ALU2(ALU2), .ALUop(ALUop), .illegal(illegal), .fault(fault), .halted(halted),
    .state(state)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct packed {
    logic mr, mw, rf, pc, ir, fw, il, flt, hlt;
    logic [2:0] a2, aop;
  } ctl_t;

  ctl_t exp_q[$];
  bit   ack_q[$];
  int   ncmp = 0;
  int   nerr = 0;

  function automatic ctl_t sample();
    ctl_t o;
    o.mr = MemRead; o.mw = MemWrite; o.rf = RFWrite; o.pc = PCwrite; o.ir = IRload;
    o.fw = FlagWrite; o.il = illegal; o.flt = fault; o.hlt = halted;
    o.a2 = ALU2; o.aop = ALUop;
    return o;
  endfunction

  task automatic check(input string tag, input ctl_t e);
    ctl_t o;
    o = sample();
    ncmp++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic check_bits(input string tag, input logic [7:0] o, input logic [7:0] e);
    ncmp++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic push(input ctl_t c, input bit a);
    exp_q.push_back(c);
    ack_q.push_back(a);
  endtask

  task automatic cyc(input logic a);
    @(posedge clock); #1;
    mem_ack = a;
    #1;
  endtask

  // Expected trace for one instruction: fetch with wf waits, decode, execute
  task automatic build(input logic [3:0] op, input logic n, input logic z,
                       input int wf, input int wm);
    ctl_t c;
    string cls;
    if (op == 4'b0100 || op == 4'b0110 || op == 4'b1000) cls = "alu";
    else if (op[2:0] == 3'b011) cls = "shift";
    else if (op[2:0] == 3'b111) cls = "ori";
    else if (op == 4'b0000) cls = "load";
    else if (op == 4'b0010) cls = "store";
    else if (op == 4'b1101) cls = "bpz";
    else if (op == 4'b0101) cls = "bz";
    else if (op == 4'b1001) cls = "bnz";
`ifdef MULTICYCLE_STOP_EN
    else if (op == 4'b0001) cls = "stop";
`endif
    else cls = "illegal";

    c = '0; c.mr = 1'b1; c.a2 = 3'b001;
    for (int i = 0; i < wf; i++) push(c, 1'b0);
    c.pc = 1'b1; c.ir = 1'b1; push(c, 1'b1);
    c = '0; c.il = (cls == "illegal"); push(c, 1'($urandom_range(0, 1)));

    c = '0;
    if (cls == "alu") begin
      c.fw = 1'b1;
      c.aop = (op == 4'b0110) ? 3'b001 : (op == 4'b1000) ? 3'b011 : 3'b000;
      push(c, 1'($urandom_range(0, 1)));
      c = '0; c.rf = 1'b1; push(c, 1'($urandom_range(0, 1)));
    end else if (cls == "shift") begin
      c.fw = 1'b1; c.a2 = 3'b100; c.aop = 3'b100; push(c, 1'($urandom_range(0, 1)));
      c = '0; c.rf = 1'b1; push(c, 1'($urandom_range(0, 1)));
    end else if (cls == "ori") begin
      push(c, 1'($urandom_range(0, 1)));
      c.fw = 1'b1; c.a2 = 3'b011; c.aop = 3'b010; push(c, 1'($urandom_range(0, 1)));
      c = '0; c.rf = 1'b1; push(c, 1'($urandom_range(0, 1)));
    end else if (cls == "load") begin
      c.mr = 1'b1;
      for (int i = 0; i < wm; i++) push(c, 1'b0);
      push(c, 1'b1);
      c = '0; c.rf = 1'b1; push(c, 1'($urandom_range(0, 1)));
    end else if (cls == "store") begin
      c.mw = 1'b1;
      for (int i = 0; i < wm; i++) push(c, 1'b0);
      push(c, 1'b1);
    end else if (cls == "bpz" || cls == "bz" || cls == "bnz") begin
      c.a2 = 3'b010;
      c.pc = (cls == "bpz") ? ~n : (cls == "bz") ? z : ~z;
      push(c, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic play(input string tag, input logic [3:0] op, input logic n, input logic z);
    ctl_t e;
    while (exp_q.size() > 0) begin
      @(posedge clock); #1;
      instr = op; N = n; Z = z;
      mem_ack = ack_q.pop_front();
      e = exp_q.pop_front();
      #1;
      check(tag, e);
    end
  endtask

  task automatic run(input string tag, input logic [3:0] op, input logic n, input logic z,
                     input int wf, input int wm);
    build(op, n, z, wf, wm);
    play(tag, op, n, z);
  endtask

  // Assert reset mid-cycle, check outputs drop at once, release after an edge
  task automatic do_reset(input string tag);
    reset = 1'b1; #1;
    check({tag, "_asserted"}, '0);
    @(posedge clock); #1;
    reset = 1'b0; #1;
    check({tag, "_released"}, '0);
  endtask

  initial begin
    ctl_t c;
    logic [3:0] op;
    reset = 1'b1; N = 1'b0; Z = 1'b0; instr = 4'b0000; mem_ack = 1'b0;
    #2;
    do_reset("reset_state");

    // Zero-wait add: FETCH, DECODE, ASN3, ALU4
    run("add_nowait", 4'b0100, 1'b0, 1'b0, 0, 0);
    run("sub_nowait", 4'b0110, 1'b0, 1'b0, 0, 0);
    run("nand_nowait", 4'b1000, 1'b0, 1'b0, 0, 0);
    run("shift_nowait", 4'b0011, 1'b0, 1'b0, 0, 0);
    run("ori_nowait", 4'b0111, 1'b0, 1'b0, 0, 0);
    // Fetch with three wait cycles
    run("fetch_wait3", 4'b0100, 1'b0, 1'b0, 3, 0);
    run("load_nowait", 4'b0000, 1'b0, 1'b0, 0, 0);
    run("store_nowait", 4'b0010, 1'b0, 1'b0, 0, 0);
    // Branch on Z, both outcomes
    run("bz_z0", 4'b0101, 1'b0, 1'b0, 0, 0);
    run("bz_z1", 4'b0101, 1'b0, 1'b1, 0, 0);
    run("bnz_z0", 4'b1001, 1'b0, 1'b0, 0, 0);
    run("bpz_n1", 4'b1101, 1'b1, 1'b0, 0, 0);
    // Illegal opcode: pulse and back to fetch
    run("illegal_1010", 4'b1010, 1'b0, 1'b0, 0, 0);
    // Ack in the timeout cycle wins
    run("load_ack_at_limit", 4'b0000, 1'b0, 1'b0, 0, 4);
    run("fetch_ack_at_limit", 4'b0010, 1'b0, 1'b0, 4, 4);

`ifdef MULTICYCLE_STOP_EN
    run("stop_decode", 4'b0001, 1'b0, 1'b0, 0, 0);
    c = '0; c.hlt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1);
      check("halt_hold", c);
    end
    do_reset("halt_reset");
`else
    run("stop_illegal", 4'b0001, 1'b0, 1'b0, 0, 0);
`endif

    // Randomized instruction stream
    for (int k = 0; k < 80; k++) begin
      op = 4'($urandom_range(0, 15));
`ifdef MULTICYCLE_STOP_EN
      if (op == 4'b0001) op = 4'b0100;
`endif
      run("random", op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
    end

    // Load timeout: five waiting LOAD3 cycles, then sticky fault
    build(4'b0000, 1'b0, 1'b0, 0, 0);
    void'(exp_q.pop_back()); void'(ack_q.pop_back());
    void'(exp_q.pop_back()); void'(ack_q.pop_back());
    play("timeout_prefix", 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0);
      check_bits("timeout_wait", {6'b0, MemRead, fault}, 8'b10);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1);
      check_bits("fault_sticky", {4'b0, MemRead, MemWrite, PCwrite, fault}, 8'b0001);
    end
    do_reset("fault_reset");
    run("after_fault", 4'b0100, 1'b0, 1'b0, 0, 0);

    // Reset during STORE3 drops MemWrite immediately
    build(4'b0010, 1'b0, 1'b0, 0, 0);
    void'(exp_q.pop_back()); void'(ack_q.pop_back());
    c = '0; c.mw = 1'b1; push(c, 1'b0);
    play("store_pre_reset", 4'b0010, 1'b0, 1'b0);
    do_reset("store_reset");
    run("after_store_reset", 4'b0111, 1'b0, 1'b0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
